// File: rtl/nfc_command_getfeature_pkg.sv
// rtl/nfc_command_getfeature_pkg.sv - shared NFC generator selects, opcodes and GET FEATURES state encoding
//
// Purpose : constants and types shared by the GET FEATURES command block and
//           its R/B# synchroniser.
// Contents: atomic command generator select bits and masks, ONFI feature
//           opcodes, the all-generators-ready pattern and the FSM state type.
package nfc_command_getfeature_pkg;

    // Bit positions of the atomic command generators inside the 8-bit select
    localparam int GEN_CA_LATCH_BIT = 6;
    localparam int GEN_DATA_OUT_BIT = 5;
    localparam int GEN_DATA_IN_BIT  = 4;

    localparam logic [7:0] GEN_NONE     = 8'h00;
    localparam logic [7:0] GEN_CA_LATCH = 8'h40;
    localparam logic [7:0] GEN_DATA_OUT = 8'h20;
    localparam logic [7:0] GEN_DATA_IN  = 8'h10;

    // Generators 0..6 must all report ready before a new command is presented
    localparam logic [6:0] GEN_ALL_READY = 7'h7F;

    localparam logic [7:0] OPC_GET_FEATURE = 8'hEE;
    localparam logic [7:0] OPC_SET_FEATURE = 8'hEF;

    typedef enum logic [2:0] {
        ST_READY        = 3'd0,
        ST_CMD          = 3'd1,
        ST_ADDR         = 3'd2,
        ST_WAIT_RB_LOW  = 3'd3,
        ST_WAIT_RB_HIGH = 3'd4,
        ST_DATA_IN      = 3'd5,
        ST_HOST_OUT     = 3'd6
    } state_t;

endpackage

// File: rtl/nfc_command_getfeature_way_rb_sync.sv
// rtl/nfc_command_getfeature_way_rb_sync.sv - two-stage R/B# sampler for the selected way
//
// Purpose : masks the per-way R/B# inputs with the latched target way and
//           reduces them to one registered ready flag (1 = way ready).
// Ports   : clk, rst (sync active-high), target_way, ready_busy -> way_rb
module nfc_command_getfeature_way_rb_sync #(
    parameter int NumberOfWays = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NumberOfWays-1:0] target_way,
    input  logic [NumberOfWays-1:0] ready_busy,
    output logic                    way_rb
);

    logic [NumberOfWays-1:0] busy_vec_q, busy_vec_d;
    logic                    way_rb_q, way_rb_d;

    always_comb begin
        busy_vec_d = target_way & ready_busy;
        way_rb_d   = |busy_vec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec_q <= '0;
            way_rb_q   <= 1'b0;
        end else begin
            busy_vec_q <= busy_vec_d;
            way_rb_q   <= way_rb_d;
        end
    end

    assign way_rb = way_rb_q;

endmodule

// File: rtl/nfc_command_getfeature.sv
// rtl/nfc_command_getfeature.sv - NAND GET FEATURES command sequencer
//
// Purpose : on a matching host command, issues EEh + feature address through
//           the CA-latch generator, waits for the way to go busy then ready,
//           reads four parameter bytes through the data-in generator and
//           returns them to the host as one 32-bit word.
// Ports   : host command (iOpcode/iTargetID/iAddress/iCMDValid/oCMDReady),
//           oStart/oLastStep status, host read word (oReadData/oReadLast/
//           oReadValid/iReadReady), atomic generator control (oACG_*),
//           generator read stream (iACG_Read*/oACG_ReadReady), per-way R/B#.
module nfc_command_getfeature
    import nfc_command_getfeature_pkg::*;
#(
    parameter int         NumberOfWays = 4,
    parameter logic [5:0] CommandID    = 6'b000011,
    parameter logic [4:0] TargetID     = 5'b00101,
    parameter int         RBLowTimeout = 16
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic [4:0]              iSourceID,
    input  logic [31:0]             iAddress,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    output logic                    oStart,
    output logic                    oLastStep,
    output logic [31:0]             oReadData,
    output logic                    oReadLast,
    output logic                    oReadValid,
    input  logic                    iReadReady,
    output logic [7:0]              oACG_Command,
    output logic [2:0]              oACG_CommandOption,
    input  logic [7:0]              iACG_Ready,
    input  logic [7:0]              iACG_LastStep,
    output logic [NumberOfWays-1:0] oACG_TargetWay,
    output logic [15:0]             oACG_NumOfData,
    output logic                    oACG_CASelect,
    output logic [39:0]             oACG_CAData,
    input  logic [15:0]             iACG_ReadData,
    input  logic                    iACG_ReadLast,
    input  logic                    iACG_ReadValid,
    output logic                    oACG_ReadReady,
    input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

    state_t                  state_q, state_d;
    logic [NumberOfWays-1:0] way_q, way_d;
    logic [7:0]              feat_addr_q, feat_addr_d;
    logic [31:0]             read_data_q, read_data_d;
    logic [1:0]              beat_cnt_q, beat_cnt_d;
    logic [15:0]             rb_cnt_q, rb_cnt_d;

    logic way_rb;
    logic gen_ready;
    logic rb_timeout;
    logic unused_inputs;

    // Source ID, upper address bits and the generator handshakes this command
    // never uses are folded here so they are visibly intentional.
    assign unused_inputs = ^{iSourceID, iAddress[31:8], iACG_Ready[7],
                             iACG_LastStep[7], iACG_LastStep[5], iACG_LastStep[3:0]};

    assign oStart     = (iOpcode == CommandID) & (iTargetID == TargetID) & iCMDValid;
    assign gen_ready  = (iACG_Ready[6:0] == GEN_ALL_READY);
    // Counter holds the number of completed cycles in WAIT_RB_LOW
    assign rb_timeout = (rb_cnt_q == 16'(RBLowTimeout - 1));

    nfc_command_getfeature_way_rb_sync #(
        .NumberOfWays(NumberOfWays)
    ) u_way_rb_sync (
        .clk        (iSystemClock),
        .rst        (iReset),
        .target_way (way_q),
        .ready_busy (iACG_ReadyBusy),
        .way_rb     (way_rb)
    );

    // State register
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY:        if (oStart) state_d = ST_CMD;
            ST_CMD:          if (iACG_LastStep[GEN_CA_LATCH_BIT]) state_d = ST_ADDR;
            ST_ADDR:         if (iACG_LastStep[GEN_CA_LATCH_BIT]) state_d = ST_WAIT_RB_LOW;
            // The way may finish its internal read before busy is ever seen,
            // so a bounded wait keeps the sequence moving.
            ST_WAIT_RB_LOW:  if (!way_rb || rb_timeout) state_d = ST_WAIT_RB_HIGH;
            ST_WAIT_RB_HIGH: if (way_rb) state_d = ST_DATA_IN;
            ST_DATA_IN:      if ((iACG_ReadValid && iACG_ReadLast) ||
                                 iACG_LastStep[GEN_DATA_IN_BIT]) state_d = ST_HOST_OUT;
            ST_HOST_OUT:     if (iReadReady) state_d = ST_READY;
            default:         state_d = ST_READY;
        endcase
    end

    // Output logic
    always_comb begin
        oCMDReady          = 1'b0;
        oLastStep          = 1'b0;
        oReadValid         = 1'b0;
        oReadLast          = 1'b0;
        oACG_Command       = GEN_NONE;
        oACG_CommandOption = 3'b000;
        oACG_NumOfData     = 16'd0;
        oACG_CASelect      = 1'b1;
        oACG_CAData        = 40'd0;
        oACG_ReadReady     = 1'b0;
        case (state_q)
            ST_READY: oCMDReady = 1'b1;
            ST_CMD: begin
                // Generators only see a select once every one of them is idle
                oACG_Command   = gen_ready ? GEN_CA_LATCH : GEN_NONE;
                oACG_CASelect  = 1'b1;
                oACG_NumOfData = 16'd1;
                oACG_CAData    = {OPC_GET_FEATURE, 32'h0};
            end
            ST_ADDR: begin
                oACG_Command   = gen_ready ? GEN_CA_LATCH : GEN_NONE;
                oACG_CASelect  = 1'b0;
                oACG_NumOfData = 16'd1;
                oACG_CAData    = {feat_addr_q, 32'h0};
            end
            ST_DATA_IN: begin
                oACG_Command   = gen_ready ? GEN_DATA_IN : GEN_NONE;
                oACG_NumOfData = 16'd4;
                oACG_ReadReady = 1'b1;
            end
            ST_HOST_OUT: begin
                oReadValid = 1'b1;
                oReadLast  = 1'b1;
                oLastStep  = iReadReady;
            end
            default: ;
        endcase
    end

    // Datapath: latched way/address, collected feature word, beat and timeout counters
    always_comb begin
        way_d       = way_q;
        feat_addr_d = feat_addr_q;
        read_data_d = read_data_q;
        beat_cnt_d  = beat_cnt_q;
        rb_cnt_d    = 16'd0;
        if (state_q == ST_WAIT_RB_LOW) begin
            rb_cnt_d = rb_cnt_q + 16'd1;
        end
        if (state_q == ST_READY && oStart) begin
            way_d       = iWaySelect;
            feat_addr_d = iAddress[7:0];
            beat_cnt_d  = 2'd0;
        end
        if (state_q == ST_DATA_IN && iACG_ReadValid) begin
            case (beat_cnt_q)
                // Low half cleared so a single-beat read returns zero there
                2'd0: begin
                    read_data_d = {iACG_ReadData, 16'h0000};
                    beat_cnt_d  = 2'd1;
                end
                2'd1: begin
                    read_data_d[15:0] = iACG_ReadData;
                    beat_cnt_d        = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            way_q       <= '0;
            feat_addr_q <= 8'd0;
            read_data_q <= 32'd0;
            beat_cnt_q  <= 2'd0;
            rb_cnt_q    <= 16'd0;
        end else begin
            way_q       <= way_d;
            feat_addr_q <= feat_addr_d;
            read_data_q <= read_data_d;
            beat_cnt_q  <= beat_cnt_d;
            rb_cnt_q    <= rb_cnt_d;
        end
    end

    assign oACG_TargetWay = way_q;
    assign oReadData      = read_data_q;

endmodule

// File: doc/nfc_command_getfeature.md
NFC_COMMAND_GETFEATURE -- requirements
Module: NFC_Command_GetFeature

Interface
REQ-001 SHALL have parameter NumberOfWays, default 4, giving the number of NAND ways (width of way vectors).
REQ-002 SHALL have parameter CommandID, default 6'b000011, giving the opcode that triggers GET FEATURES.
REQ-003 SHALL have parameter TargetID, default 5'b00101, giving the target ID this block answers to.
REQ-004 SHALL have parameter RBLowTimeout, default 16, giving the cycles allowed in WAIT_RB_LOW before forcing progress.
REQ-005 SHALL have ports, in this order:
  iSystemClock  in  1  sole clock; all logic on rising edge
  iReset  in  1  synchronous, active-high reset
  iOpcode  in  6  host opcode
  iTargetID  in  5  host target ID
  iSourceID  in  5  host source ID; unused
  iAddress  in  32  [7:0] = feature address; rest ignored
  iCMDValid  in  1  host command valid
  oCMDReady  out  1  block idle, accepts command
  iWaySelect  in  NumberOfWays  one-hot target way
  oStart  out  1  combinational command-match pulse
  oLastStep  out  1  one-cycle completion pulse
  oReadData  out  32  feature parameters P1..P4
  oReadLast  out  1  high with every oReadValid beat
  oReadValid  out  1  feature word valid
  iReadReady  in  1  host accepts feature word
  oACG_Command  out  8  one-hot atomic-generator select
  oACG_CommandOption  out  3  always 3'b000
  iACG_Ready  in  8  per-generator ready
  iACG_LastStep  in  8  per-generator done pulse
  oACG_TargetWay  out  NumberOfWays  latched way
  oACG_NumOfData  out  16  byte count for the active generator
  oACG_CASelect  out  1  1 = command cycle, 0 = address cycle
  oACG_CAData  out  40  command/address bytes, first byte in [39:32]
  iACG_ReadData  in  16  read data beat
  iACG_ReadLast  in  1  last read beat
  iACG_ReadValid  in  1  read beat valid
  oACG_ReadReady  out  1  read beat accepted
  iACG_ReadyBusy  in  NumberOfWays  per-way R/B#, 1 = ready

Function
REQ-006 SHALL drive oStart = (iOpcode==CommandID) & (iTargetID==TargetID) & iCMDValid.
REQ-007 SHALL treat the generators as ready when iACG_Ready[6:0] == 7'h7F.
REQ-008 SHALL implement FSM states READY, CMD, ADDR, WAIT_RB_LOW, WAIT_RB_HIGH, DATA_IN, HOST_OUT.
REQ-009 READY SHALL go to CMD on oStart, latching iWaySelect into oACG_TargetWay and iAddress[7:0] as the feature address; oCMDReady = 1 only in READY.
REQ-010 CMD SHALL drive oACG_Command = 8'h40, oACG_CASelect = 1, oACG_NumOfData = 1, oACG_CAData = {8'hEE, 32'h0}, and go to ADDR on iACG_LastStep[6].
REQ-011 ADDR SHALL drive oACG_Command = 8'h40, oACG_CASelect = 0, oACG_NumOfData = 1, oACG_CAData = {featureAddr, 32'h0}, and go to WAIT_RB_LOW on iACG_LastStep[6].
REQ-012 The R/B# path SHALL be two registers: rBusyVec <= oACG_TargetWay & iACG_ReadyBusy, then rWayRB <= |rBusyVec.
REQ-013 WAIT_RB_LOW SHALL go to WAIT_RB_HIGH when rWayRB == 0 or after RBLowTimeout cycles in the state, whichever is first.
REQ-014 WAIT_RB_HIGH SHALL go to DATA_IN when rWayRB == 1.
REQ-015 DATA_IN SHALL drive oACG_Command = 8'h10, oACG_NumOfData = 4, and oACG_ReadReady = 1; beat 0 goes to oReadData[31:16], beat 1 goes to [15:0].
REQ-016 Beats after the second SHALL be accepted and discarded; if iACG_ReadLast arrives on beat 0, [15:0] SHALL be zero.
REQ-017 DATA_IN SHALL go to HOST_OUT on the accepted beat with iACG_ReadLast = 1 or on iACG_LastStep[4], whichever is first.
REQ-018 HOST_OUT SHALL hold oReadValid = oReadLast = 1 with stable oReadData until iReadReady; on that cycle it SHALL go to READY and pulse oLastStep for exactly one cycle.
REQ-019 oACG_Command SHALL be 0 in READY, WAIT_RB_LOW, WAIT_RB_HIGH and HOST_OUT; oACG_ReadReady SHALL be 0 outside DATA_IN.
REQ-020 oStart asserted while not in READY SHALL be ignored (no queuing).

Reset
REQ-021 On iReset = 1 at a clock edge, the FSM SHALL enter READY from any state, including mid-transfer.
REQ-022 Reset values: oCMDReady = 1, oLastStep = 0, oReadValid = 0, oReadLast = 0, oReadData = 0, oACG_Command = 0, oACG_CommandOption = 0, oACG_TargetWay = 0, oACG_NumOfData = 0, oACG_CASelect = 1, oACG_CAData = 0, oACG_ReadReady = 0; R/B registers and the timeout counter are cleared.

Structure
REQ-023 Generator select bits (bit 6 = CA latch, bit 5 = data out, bit 4 = data in), opcode 8'hEE/8'hEF and the state encodings SHALL live in the shared NFC package.
REQ-024 SHALL be one flat module; the R/B synchroniser MAY be factored as sub-module NFC_WayReadyBusySync.

Verification
REQ-025 Command at feature address 0x01; R/B drops 3 cycles after ADDR, rises 50 cycles later; read beats 0x1500, 0x0000 -> CA sequence EEh then 01h, oReadData = 0x15000000, one oLastStep pulse.
REQ-026 R/B never drops -> WAIT_RB_LOW exits after exactly 16 cycles and the transfer completes normally.
REQ-027 iReadReady held low 20 cycles -> oReadValid stays high with oReadData stable; completion occurs on the ready cycle.
REQ-028 Three read beats 0xAAAA, 0xBBBB, 0xCCCC (last on the third) -> oReadData = 0xAAAABBBB.
REQ-029 iReset pulsed during DATA_IN -> next cycle READY, all outputs at reset values; a subsequent command completes.
REQ-030 Non-matching opcode, or second command while busy -> oStart behaves per REQ-006, the FSM does not react, and oACG_Command stays 0.
